// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the shared shift-and-add multiplier arbiter.
package mult_share_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;
  localparam int MAX_NREQ  = 16;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // First valid index at or after ptr, wrapping modulo n; returns ptr when nothing is valid.
  function automatic logic [3:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                         input logic [3:0]          ptr,
                                         input int                  n);
    int idx;
    rr_pick = ptr;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (valid[idx[3:0]]) rr_pick = idx[3:0];
      end
    end
  endfunction

endpackage

// File: rtl/mult_iter_core.sv
// Iterative shift-and-add datapath: one multiplier bit per step.
// MULT_SHARE_ARB_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module mult_iter_core
  import mult_share_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplr, mplr_next;
  logic [CW-1:0]      count;

  assign mplr_next = mplr >> 1;
  assign acc_next  = mplr[0] ? acc + mcand : acc;

`ifdef MULT_SHARE_ARB_EARLY_EXIT_EN
  assign done = (count == CW'(1)) || (mplr_next == '0);
`else
  assign done = (count == CW'(1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      mcand <= {{WIDTH{1'b0}}, a};
      mplr  <= b;
      acc   <= '0;
      count <= CW'(WIDTH);
    end else if (step) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr_next;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one iterative multiplier among NREQ requesters.
// MULT_SHARE_ARB_EARLY_EXIT_EN (in mult_iter_core) shortens latency for small multipliers.
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREQ  = DEF_NREQ,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [2*WIDTH-1:0]         rsp_product,
  output logic                       busy
);

  state_t             state, state_nxt;
  logic [IDW-1:0]     rr_ptr, id, grant;
  logic               any_valid, load, step, done;
  logic [2*WIDTH-1:0] acc_next;

  assign grant     = IDW'(rr_pick(MAX_NREQ'(req_valid), 4'(rr_ptr), NREQ));
  assign any_valid = |req_valid;
  assign busy      = (state != IDLE);

  mult_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .a        (req_a[grant]),
    .b        (req_b[grant]),
    .acc_next (acc_next),
    .done     (done)
  );

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    load      = 1'b0;
    step      = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: if (any_valid) begin
        req_ready[grant] = 1'b1;
        load             = 1'b1;
        state_nxt        = BUSY;
      end
      BUSY: begin
        step = 1'b1;
        if (done) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result is latched on the final step so it stays put while the core reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      id          <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        id     <= grant;
        rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + IDW'(1);
      end
      if (step && done) begin
        rsp_product <= acc_next;
        rsp_id      <= id;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Randomized + directed bench for mult_share_arb against a transaction-level model.
module tb_mult_share_arb;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NREQ-1:0]            req_valid, req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a, req_b;
  logic                       rsp_valid, rsp_ready;
  logic [1:0]                 rsp_id;
  logic [2*WIDTH-1:0]         rsp_product;
  logic                       busy;

  always #5 clk = ~clk;

  mult_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction model: idle/in-flight, cycles since accept, expected result.
  bit              m_busy;
  int              m_k, m_lat, m_ptr, m_id;
  longint unsigned m_prod;

  bit              rand_en;
  logic [NREQ-1:0] sticky;
  int              rdy_mode;  // 0 random, 1 high, 2 low
  int              ncyc, acc_cyc;
  bit              seen;
  int              g_log[$], id_log[$], lat_log[$];
  longint unsigned prod_log[$];

  function automatic int lat_of(input int b);
`ifdef MULT_SHARE_ARB_EARLY_EXIT_EN
    int l = 1;
    for (int i = 0; i < WIDTH; i++) if ((b >> i) & 1) l = i + 1;
    return l;
`else
    return WIDTH;
`endif
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  task automatic new_op(input int i);
    req_valid[i] = 1'b1;
    req_a[i] = ($urandom_range(7) == 0) ? '0 : WIDTH'($urandom);
    req_b[i] = ($urandom_range(7) == 0) ? '0 : WIDTH'($urandom);
  endtask

  task automatic clear_logs();
    g_log.delete(); id_log.delete(); lat_log.delete(); prod_log.delete();
  endtask

  task automatic tick();
    int g;
    bit fire_rsp, exp_v;
    logic [NREQ-1:0] exp_rdy;
    logic [1:0] oid;
    logic [2*WIDTH-1:0] oprod;
    @(negedge clk);
    exp_rdy = '0;
    g = -1;
    if (!m_busy) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    exp_v = m_busy && (m_k >= m_lat);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
    fire_rsp = 1'b0;
    oid = rsp_id;
    oprod = rsp_product;
    if (rsp_valid && !seen) begin
      lat_log.push_back(ncyc - acc_cyc);
      seen = 1'b1;
    end
    if (exp_v) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_product", 64'(rsp_product), m_prod);
      fire_rsp = rsp_ready;
    end
    @(posedge clk);
    ncyc++;
    if (g >= 0) begin
      m_busy = 1'b1; m_k = 0; m_id = g;
      m_prod = longint'(req_a[g]) * longint'(req_b[g]);
      m_lat  = lat_of(int'(req_b[g]));
      m_ptr  = (g + 1) % NREQ;
      g_log.push_back(g);
      acc_cyc = ncyc;
      seen = 1'b0;
    end else if (fire_rsp) begin
      m_busy = 1'b0;
      id_log.push_back(int'(oid));
      prod_log.push_back(64'(oprod));
    end else if (m_busy) begin
      m_k++;
    end
    #1;
    if (g >= 0) begin
      if (sticky[g] || (rand_en && $urandom_range(1) == 0)) new_op(g);
      else req_valid[g] = 1'b0;
    end
    if (rand_en)
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && i != g && $urandom_range(2) == 0) new_op(i);
    rsp_ready = (rdy_mode == 0) ? 1'($urandom_range(1)) : (rdy_mode == 1);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((m_busy || req_valid != '0) && t < budget) begin
      tick();
      t++;
    end
    if (m_busy || req_valid != '0) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_product"}, 64'(rsp_product), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Caller is in the post-posedge window; returns in the same window.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk_reset_outs(tag);
    m_busy = 1'b0; m_ptr = 0; m_k = 0; seen = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic single(input int i, input int a, input int b);
    req_a[i] = WIDTH'(a);
    req_b[i] = WIDTH'(b);
    req_valid[i] = 1'b1;
  endtask

  initial begin
    rand_en = 1'b0; sticky = '0; rdy_mode = 1; ncyc = 0; acc_cyc = 0; seen = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1; rst = 1'b0;
    m_busy = 1'b0; m_k = 0; m_lat = WIDTH; m_ptr = 0; m_id = 0; m_prod = 0;
    #2;
    do_reset("por");

    // All four at once, two rounds: pointer should wrap back to 0.
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      for (int i = 0; i < NREQ; i++) single(i, i + 1, 3);
      drain(200);
      for (int i = 0; i < NREQ; i++) begin
        chk($sformatf("all4_r%0d_grant%0d", r, i), 64'(g_log.size() > i ? g_log[i] : -1), 64'(i));
        chk($sformatf("all4_r%0d_prod%0d", r, i), prod_log.size() > i ? prod_log[i] : 64'hdead, 64'(3 * (i + 1)));
      end
    end

    clear_logs();
    single(0, 255, 255);
    drain(100);
    chk("single_id", 64'(id_log.size() > 0 ? id_log[0] : -1), 64'd0);
    chk("single_prod", prod_log.size() > 0 ? prod_log[0] : 64'hdead, 64'hFE01);
    chk("single_lat", 64'(lat_log.size() > 0 ? lat_log[0] : -1), 64'd8);

    // Stall with rsp_ready low for 5 cycles of RESP.
    clear_logs();
    rdy_mode = 2;
    rsp_ready = 1'b0;
    single(2, 13, 11);
    for (int t = 0; t < 50 && !(m_busy && m_k >= m_lat); t++) tick();
    if (!(m_busy && m_k >= m_lat)) chk("stall_timeout", 64'd1, 64'd0);
    repeat (5) tick();
    rdy_mode = 1;
    rsp_ready = 1'b1;
    drain(50);
    chk("stall_prod", prod_log.size() > 0 ? prod_log[0] : 64'hdead, 64'd143);
    chk("stall_id", 64'(id_log.size() > 0 ? id_log[0] : -1), 64'd2);

    // Fairness: 1 and 3 always valid.
    clear_logs();
    sticky = 4'b1010;
    single(1, 5, 6);
    single(3, 7, 8);
    for (int t = 0; t < 300 && g_log.size() < 6; t++) tick();
    sticky = '0;
    drain(100);
    if (g_log.size() < 6) chk("fair_timeout", 64'd1, 64'd0);
    for (int i = 1; i < 6 && i < g_log.size(); i++) begin
      chk($sformatf("fair_alt%0d", i), 64'(g_log[i] != g_log[i-1]), 64'd1);
      chk($sformatf("fair_who%0d", i), 64'(g_log[i] == 1 || g_log[i] == 3), 64'd1);
    end

    // Reset three cycles into BUSY.
    clear_logs();
    single(0, 7, 9);
    for (int t = 0; t < 50 && !(m_busy && m_k == 3); t++) tick();
    if (!(m_busy && m_k == 3)) chk("midrst_timeout", 64'd1, 64'd0);
    do_reset("midrst");
    for (int t = 0; t < 12; t++) tick();
    chk("midrst_no_rsp", 64'(prod_log.size()), 64'd0);
    single(1, 2, 5);
    drain(100);
    chk("postrst_prod", prod_log.size() > 0 ? prod_log[0] : 64'hdead, 64'd10);

    // Latency vs multiplier shape (early exit when built with the macro).
    clear_logs();
    single(0, 200, 1);    drain(100);
    single(0, 200, 8'h80); drain(100);
    single(0, 200, 0);    drain(100);
    chk("ee_prod0", prod_log.size() > 0 ? prod_log[0] : 64'hdead, 64'd200);
    chk("ee_prod1", prod_log.size() > 1 ? prod_log[1] : 64'hdead, 64'd25600);
    chk("ee_prod2", prod_log.size() > 2 ? prod_log[2] : 64'hdead, 64'd0);
`ifdef MULT_SHARE_ARB_EARLY_EXIT_EN
    chk("ee_lat0", 64'(lat_log.size() > 0 ? lat_log[0] : -1), 64'd1);
    chk("ee_lat2", 64'(lat_log.size() > 2 ? lat_log[2] : -1), 64'd1);
`else
    chk("ee_lat0", 64'(lat_log.size() > 0 ? lat_log[0] : -1), 64'd8);
    chk("ee_lat2", 64'(lat_log.size() > 2 ? lat_log[2] : -1), 64'd8);
`endif
    chk("ee_lat1", 64'(lat_log.size() > 1 ? lat_log[1] : -1), 64'd8);

    // Random traffic with random backpressure.
    rand_en = 1'b1;
    rdy_mode = 0;
    repeat (1500) tick();
    rand_en = 1'b0;
    rdy_mode = 1;
    rsp_ready = 1'b1;
    drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one iterative shift-and-add multiplier engine among NREQ requesters.
- Round-robin arbitration picks a requester; operands are captured with a valid/ready handshake.
- The engine sequences WIDTH iterations, then returns the 2*WIDTH-bit product tagged with the requester index over a valid/ready response channel.
- Sits between client datapaths and the shared multiplier, where area matters more than throughput.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), width of the requester index (derived, not overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  input  NREQ*WIDTH  multiplicands; slice i belongs to requester i.
- req_b  input  NREQ*WIDTH  multipliers; slice i belongs to requester i.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_product  output  2*WIDTH  unsigned product A*B.
- busy  output  1  high in BUSY or RESP.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, count=0, internal regs=0.
- Reset output values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0.
- Reset asserted mid-operation: abort immediately; the in-flight result is discarded and never presented.
- States:
  - IDLE: grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - IDLE: req_ready[g]=1 (combinational), all other req_ready bits 0. No valid request means all req_ready=0 and stay IDLE.
  - IDLE accept edge (req_valid[g]&req_ready[g]): capture mcand={0,req_a[g]}, mplr=req_b[g], acc=0, id=g, count=WIDTH; rr_ptr<=(g+1) mod NREQ; go to BUSY.
  - BUSY: one iteration per clock. If mplr[0], acc<=acc+mcand. Then mcand<<=1, mplr>>=1, count<=count-1.
  - BUSY: the iteration with count==1 transfers to RESP.
  - RESP: rsp_valid=1, rsp_product=acc, rsp_id=id. All held stable until rsp_ready=1, then go to IDLE.
  - rsp_ready low stalls indefinitely with no data change. req_ready=0 in BUSY and RESP.
- Latency: rsp_valid rises exactly WIDTH clocks after the accept edge.
  - Earliest next accept is the edge after the response handshake.
  - Minimum issue interval is WIDTH+2 cycles.
- Arithmetic:
  - Unsigned; acc is 2*WIDTH bits and never overflows (max (2^W-1)^2).
  - Additions are truncated to 2*WIDTH bits by construction.
- rsp_product and rsp_id are registered and hold their last value outside RESP, but are only meaningful while rsp_valid=1.
- Requester rules:
  - Once req_valid is asserted, hold it and operands stable until accepted.
  - The block does not check for violations.
  - A requester may reassert immediately after acceptance. The round-robin pointer guarantees every valid requester is served within NREQ grants.
- Zero operands (A=0 or B=0): normal latency, product 0.

Optional Feature:
- Macro: MULT_SHARE_ARB_EARLY_EXIT_EN.
- Defined: in BUSY, when the next mplr value (after shift) is 0, transfer to RESP on that edge regardless of count.
  - Latency = max(1, index of highest set bit of B + 1) cycles.
  - B=0 gives 1 cycle.
- Undefined: fixed WIDTH-cycle latency as above.
- Results are identical either way.

Decomposition:
- Package mult_share_pkg:
  - state enum typedef {IDLE, BUSY, RESP}.
  - Default WIDTH/NREQ localparams.
  - Function rr_pick(valid, ptr) returning the grant index.
- One sub-module, mult_iter_core: datapath registers mcand/mplr/acc/count with load/step/done signals.
- Arbiter and FSM stay in the top.

Test Plan:
- Single request: req 0, A=8'd255, B=8'd255 -> rsp_valid 8 cycles after accept, rsp_product=16'hFE01, rsp_id=0.
- All four requesters valid at once, A=i+1, B=3 -> grants in order 0,1,2,3; products 3,6,9,12. Next round starts at 0 again after rr_ptr wraps.
- Stall: hold rsp_ready=0 for 5 cycles, A=13, B=11 -> rsp_valid/product 143/id stable throughout. req_ready stays 0 until the handshake, then IDLE.
- Fairness: requesters 1 and 3 continuously valid -> grants alternate 1,3,1,3. Neither is granted twice in a row.
- Reset mid-op: assert rst 3 cycles into BUSY -> all outputs 0 next observation, no rsp_valid. Post-reset request A=2, B=5 returns 10.
- Early exit (macro on): A=200, B=1 -> rsp_valid 1 cycle after accept, product 200. B=8'h80 -> 8 cycles, product 25600.
